usb_cmd_decoder: RTL and testbench

- Consumes the 8-bit host→FPGA AXI-stream from the FTDI 245-FIFO controller's RX side (rx_clk domain = clk).
- Assembles fixed 8-byte commands and decodes them: writes a bank of 32-bit control registers, or returns a single 32-bit response word.
- Responses go out on a 32-bit AXI-stream that feeds the controller's TX side (TX_EW=2).

---
 rtl/usb_cmd_decoder.sv | 170 +++++++++++++++++
 tb/tb_usb_cmd_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: assembles 8-byte host commands from the FTDI RX
// byte stream, drives a bank of 32-bit control registers and returns
// one-word responses on the 32-bit TX stream.
// Ports:
//   clk, rst                           clock, sync active-high reset
//   i_tvalid/i_tready/i_tdata[7:0]     RX byte stream in
//   o_tvalid/o_tready/o_tdata[31:0]    TX response word out
//   o_tkeep[3:0], o_tlast              all ones / one whenever o_tvalid
//   reg_out[NREG*32-1:0]               register k at [32k+31:32k]
//   wr_pulse[NREG-1:0]                 one-cycle write strobe per register
module usb_cmd_decoder #(
  parameter int NREG    = 16,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i_tready,
  input  logic                 i_tvalid,
  input  logic [7:0]           i_tdata,
  input  logic                 o_tready,
  output logic                 o_tvalid,
  output logic [31:0]          o_tdata,
  output logic [3:0]           o_tkeep,
  output logic                 o_tlast,
  output logic [NREG*32-1:0]   reg_out,
  output logic [NREG-1:0]      wr_pulse
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, RESP} state_e;

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          op_q, op_d;
  logic [7:0]          addr_q, addr_d;
  logic [23:0]         dlo_q, dlo_d;
  logic [NREG*32-1:0]  regs_q, regs_d;
  logic [NREG-1:0]     pulse_q, pulse_d;
  logic                vld_q, vld_d;
  logic [31:0]         rsp_q, rsp_d;
  logic                rdy_q, rdy_d;

  logic                hs;
  logic [31:0]         data;
  logic [31:0]         rd;

  // Byte 7 is not stored: the command decodes as it arrives.
  always_comb begin
    hs   = i_tvalid & rdy_q;
    data = {i_tdata, dlo_q};
    rd   = '0;
    for (int k = 0; k < NREG; k++) begin
      if (addr_q == 8'(k)) rd = regs_q[32*k +: 32];
    end

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    dlo_d   = dlo_q;
    regs_d  = regs_q;
    pulse_d = '0;
    vld_d   = vld_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      COLLECT: begin
        if (hs) begin
          idx_d = idx_q + 3'd1;
          cnt_d = '0;
          case (idx_q)
            3'd0: op_d = i_tdata;
            3'd1: addr_d = i_tdata;
            3'd4: dlo_d[7:0] = i_tdata;
            3'd5: dlo_d[15:8] = i_tdata;
            3'd6: dlo_d[23:16] = i_tdata;
            3'd7: begin
              case (op_q)
                8'h01: begin
                  for (int k = 0; k < NREG; k++) begin
                    if (addr_q == 8'(k)) begin
                      regs_d[32*k +: 32] = data;
                      pulse_d[k] = 1'b1;
                    end
                  end
                end
                8'h02: begin
                  rsp_d   = rd;
                  vld_d   = 1'b1;
                  state_d = RESP;
                end
                8'h03: begin
                  rsp_d   = data;
                  vld_d   = 1'b1;
                  state_d = RESP;
                end
                default: begin
                  rsp_d   = {16'h0000, op_q, 8'hEE};
                  vld_d   = 1'b1;
                  state_d = RESP;
                end
              endcase
            end
            default: ;
          endcase
        end else if (idx_q != 3'd0) begin
          if (cnt_q == TMAX) begin
            idx_d = '0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      RESP: begin
        cnt_d = '0;
        if (o_tready) begin
          vld_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    rdy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      dlo_q   <= '0;
      regs_q  <= '0;
      pulse_q <= '0;
      vld_q   <= 1'b0;
      rsp_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      dlo_q   <= dlo_d;
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      vld_q   <= vld_d;
      rsp_q   <= rsp_d;
      rdy_q   <= rdy_d;
    end
  end

  assign i_tready = rdy_q;
  assign o_tvalid = vld_q;
  assign o_tdata  = rsp_q;
  assign o_tkeep  = {4{vld_q}};
  assign o_tlast  = vld_q;
  assign reg_out  = regs_q;
  assign wr_pulse = pulse_q;

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// tb_usb_cmd_decoder: directed vector table plus hand-written
// sequences for timeout, back-to-back commands and reset in RESP.
module tb_usb_cmd_decoder;

  localparam int NREG = 16;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst;
  logic i_tready;
  logic i_tvalid;
  logic [7:0] i_tdata;
  logic o_tready;
  logic o_tvalid;
  logic [31:0] o_tdata;
  logic [3:0] o_tkeep;
  logic o_tlast;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0] wr_pulse;

  int n_cmp = 0;
  int n_fail = 0;
  logic [NREG*32-1:0] mdl;

  usb_cmd_decoder #(.NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
    .o_tkeep(o_tkeep), .o_tlast(o_tlast),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cmd;
    bit          rsp;
    logic [31:0] exp;
    logic [15:0] pulse;
    int          stall;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [NREG*32-1:0] act,
                     input logic [NREG*32-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    i_tvalid = 1'b1;
    i_tdata = b;
    forever begin
      @(negedge clk);
      if (i_tready) break;
      n++;
      if (n > 200) begin
        chk("rx_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_cmd(input logic [63:0] c);
    for (int i = 0; i < 8; i++) send_byte(c[8*i +: 8]);
  endtask

  task automatic get_resp(input int stall, output logic [31:0] d,
                          output int w, output bit bad);
    w = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!o_tvalid && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("resp_valid_seen", {511'b0, o_tvalid}, 1);
    d = o_tdata;
    if (o_tkeep !== 4'hF || o_tlast !== 1'b1) bad = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (i_tready) bad = 1'b1;
      @(negedge clk);
      if (o_tdata !== d || !o_tvalid) bad = 1'b1;
    end
    if (i_tready) bad = 1'b1;
    o_tready = 1'b1;
    @(posedge clk);
    #1;
    o_tready = 1'b0;
    if (o_tvalid) bad = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl = '0;
  endtask

  logic [31:0] d, d2;
  int w, w2;
  bit bad, bad2;
  int a;

  initial begin
    vt[0]  = '{64'h12345678_ABCD_0301, 0, 32'h0, 16'h0008, 0};
    vt[1]  = '{64'h00000000_0000_0302, 1, 32'h12345678, 16'h0, 5};
    vt[2]  = '{64'hA5A55A5A_0000_0F01, 0, 32'h0, 16'h8000, 0};
    vt[3]  = '{64'h00000000_0000_0F02, 1, 32'hA5A55A5A, 16'h0, 0};
    vt[4]  = '{64'hDEADBEEF_0000_057A, 1, 32'h00007AEE, 16'h0, 2};
    vt[5]  = '{64'hFFFFFFFF_0000_4001, 0, 32'h0, 16'h0, 0};
    vt[6]  = '{64'hFFFFFFFF_0000_4002, 1, 32'h0, 16'h0, 0};
    vt[7]  = '{64'h89ABCDEF_0000_0003, 1, 32'h89ABCDEF, 16'h0, 1};
    vt[8]  = '{64'h00000000_0000_0000, 1, 32'h000000EE, 16'h0, 0};
    vt[9]  = '{64'h00000000_0000_0002, 1, 32'h0, 16'h0, 0};
    vt[10] = '{64'h00000001_0000_0001, 0, 32'h0, 16'h0001, 0};
    vt[11] = '{64'h00000000_0000_0302, 1, 32'h12345678, 16'h0, 3};
    vt[12] = '{64'h11111111_0000_12FF, 1, 32'h0000FFEE, 16'h0, 0};

    rst = 1'b1;
    i_tvalid = 1'b0;
    i_tdata = '0;
    o_tready = 1'b0;
    mdl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_tready", {511'b0, i_tready}, 0);
    chk("rst_o_tvalid", {511'b0, o_tvalid}, 0);
    chk("rst_o_tdata", {480'b0, o_tdata}, 0);
    chk("rst_keep_last", {507'b0, o_tkeep, o_tlast}, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_wr_pulse", {496'b0, wr_pulse}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_i_tready", {511'b0, i_tready}, 1);

    for (int i = 0; i < 13; i++) begin
      send_cmd(vt[i].cmd);
      if (vt[i].rsp) begin
        get_resp(vt[i].stall, d, w, bad);
        chk($sformatf("v%0d_data", i), {480'b0, d}, {480'b0, vt[i].exp});
        chk($sformatf("v%0d_latency", i), 512'(w), 0);
        chk($sformatf("v%0d_protocol", i), {511'b0, bad}, 0);
      end else begin
        a = int'(vt[i].cmd[15:8]);
        if (a < NREG) mdl[32*a +: 32] = vt[i].cmd[63:32];
        chk($sformatf("v%0d_regs", i), reg_out, mdl);
        chk($sformatf("v%0d_pulse", i), {496'b0, wr_pulse},
            {496'b0, vt[i].pulse});
        chk($sformatf("v%0d_no_resp", i), {511'b0, o_tvalid}, 0);
        chk($sformatf("v%0d_no_stall", i), {511'b0, i_tready}, 1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_pulse_off", i), {496'b0, wr_pulse}, 0);
      end
    end

    fork
      begin
        send_cmd(64'hCAFEBABE_0000_0003);
        send_cmd(64'h00000000_0000_1402);
      end
      begin
        get_resp(0, d, w, bad);
        get_resp(2, d2, w2, bad2);
      end
    join
    chk("b2b_echo", {480'b0, d}, {480'b0, 32'hCAFEBABE});
    chk("b2b_read20", {480'b0, d2}, 0);
    chk("b2b_protocol", {510'b0, bad, bad2}, 0);

    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (10) @(posedge clk);
    #1;
    send_cmd(64'h00000001_0000_0003);
    get_resp(0, d, w, bad);
    chk("tmo_discard", {480'b0, d}, {480'b0, 32'h00000001});
    chk("tmo_discard_lat", 512'(w), 0);

    fork
      begin
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (9) @(posedge clk);
        #1;
        send_cmd(64'h00000001_0000_0003);
      end
      get_resp(0, d, w, bad);
    join
    chk("tmo_retain", {480'b0, d}, {480'b0, 32'h01000000});
    repeat (10) @(posedge clk);
    #1;

    send_cmd(64'h00000000_0000_0302);
    chk("pre_rst_valid", {511'b0, o_tvalid}, 1);
    do_reset();
    chk("rresp_o_tvalid", {511'b0, o_tvalid}, 0);
    chk("rresp_reg_out", reg_out, 0);
    chk("rresp_i_tready", {511'b0, i_tready}, 0);
    @(posedge clk);
    #1;
    chk("rresp_ready_back", {511'b0, i_tready}, 1);
    send_cmd(64'h00000000_0000_0002);
    get_resp(0, d, w, bad);
    chk("rresp_read0", {480'b0, d}, 0);
    send_cmd(64'h00000000_0000_0302);
    get_resp(0, d, w, bad);
    chk("rresp_read3", {480'b0, d}, 0);
    chk("rresp_protocol", {511'b0, bad}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
